// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LOADER_HEADER  = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: two-flop synchroniser, glitch-checked start bit, centre sampling.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);

  rx_state_t        state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d, ferr_q, ferr_d;
  logic             full_tick, half_tick;

  assign full_tick = (cnt_q == FULL_M1);
  assign half_tick = (cnt_q == HALF_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !sync2_q) state_d = RX_START;
      // Line back high at half a bit means the falling edge was a glitch
      RX_START: if (half_tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (full_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE:  cnt_d = '0;
      RX_START: if (half_tick) cnt_d = '0;
      RX_DATA: begin
        if (full_tick) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (full_tick) begin
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  assign rx_data  = shift_q;

endmodule

// File: rtl/uart_program_loader.sv
// Streams a framed program image from the UART into RAM, holding the CPU in reset meanwhile.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115200,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  loader_state_t         state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, word_q, word_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            chk_q, chk_d, len_lo_q, len_lo_d;
  logic [LEN_W-1:0]      len_q, len_d, wcnt_q, wcnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  cpu_hold_q, cpu_hold_d, done_q, done_d, error_q, error_d;
  logic [15:0]           len_rx;
  logic                  len_too_big, tmo_hit, last_word;

  assign len_rx      = {rx_data, len_lo_q};
  assign len_too_big = (32'(len_rx) > (32'd1 << ADDR_WIDTH));
  assign tmo_hit     = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));
  assign last_word   = ((wcnt_q + LEN_W'(1)) == len_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERROR)                   state_d = ST_IDLE;
    else if (state_q != ST_IDLE && rx_ferr)    state_d = ST_ERROR;
    else if (tmo_hit)                          state_d = ST_ERROR;
    else if (rx_valid) begin
      case (state_q)
        ST_IDLE:   if (rx_data == LOADER_HEADER) state_d = ST_LEN_LO;
        ST_LEN_LO: state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          if (len_too_big)       state_d = ST_ERROR;
          else if (len_rx == '0) state_d = ST_CHECK;
          else                   state_d = ST_DATA;
        end
        ST_DATA:   if (idx_q == IDX_LAST && last_word) state_d = ST_CHECK;
        ST_CHECK:  state_d = (rx_data == chk_q) ? ST_IDLE : ST_ERROR;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
    mem_addr_d  = mem_we_q ? mem_addr_q + ADDR_WIDTH'(1) : mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_d      = word_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    cpu_hold_d  = cpu_hold_q;
    error_d     = error_q;
    tmo_d       = (state_q == ST_IDLE || rx_valid) ? '0 : tmo_q + TMO_W'(1);
    if (state_q == ST_ERROR) begin
      error_d = 1'b1;
    end else if (rx_valid && !tmo_hit) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == LOADER_HEADER) begin
            cpu_hold_d = 1'b1;
            error_d    = 1'b0;
            mem_addr_d = '0;
            idx_d      = '0;
            chk_d      = '0;
            wcnt_d     = '0;
          end
        end
        ST_LEN_LO: len_lo_d = rx_data;
        ST_LEN_HI: len_d = LEN_W'(len_rx);
        ST_DATA: begin
          chk_d = chk_q + rx_data;
          word_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          // Write issues the cycle after the last byte; the address bumps one cycle later
          if (idx_q == IDX_LAST) begin
            mem_wdata_d = word_d;
            mem_we_d    = 1'b1;
            wcnt_d      = wcnt_q + LEN_W'(1);
          end
        end
        ST_CHECK: begin
          if (rx_data == chk_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      len_lo_q    <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      tmo_q       <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      tmo_q       <= tmo_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a write scoreboard fed by the stimulus.
module tb_uart_program_loader;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int AW       = 3;
  localparam int DW       = 32;
  localparam int TMO      = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic          mem_we, cpu_hold, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  uart_program_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .uart_rx   (uart_rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          we_cnt = 0;
  int          d0, w0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_we === 1'b1) begin
      we_cnt++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        assert ({mem_addr, mem_wdata} === {mon_e.addr, mon_e.data}) else begin
          n_bad++;
          $error("FAIL write: observed %0h@%0h expected %0h@%0h", mem_wdata, mem_addr, mon_e.data, mon_e.addr);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sends header, length, words from img and the checksum plus chk_err
  task automatic send_frame(input int n, input logic [7:0] chk_err);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] w;
    sum = 8'h00;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int wi = 0; wi < n; wi++) begin
      w = img[wi];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        sum = sum + b;
        if (k == 3) exp_q.push_back({AW'(wi), w});
        send_byte(b);
      end
    end
    send_byte(sum + chk_err);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_we"},    64'(mem_we),    64'd0);
    check({pfx, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({pfx, "_cpu_hold"},  64'(cpu_hold),  64'd0);
    check({pfx, "_busy"},      64'(busy),      64'd0);
    check({pfx, "_done"},      64'(done),      64'd0);
    check({pfx, "_error"},     64'(error),     64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Two-word good image
    img = '{32'h44332211, 32'hDDCCBBAA};
    d0 = done_cnt; w0 = we_cnt;
    send_frame(2, 8'd0);
    check("good_done",     64'(done_cnt - d0), 64'd1);
    check("good_writes",   64'(we_cnt - w0),   64'd2);
    check("good_sb_empty", 64'(exp_q.size()),  64'd0);
    check("good_cpu_hold", 64'(cpu_hold),      64'd0);
    check("good_error",    64'(error),         64'd0);
    check("good_busy",     64'(busy),          64'd0);
    check("good_addr",     64'(mem_addr),      64'd2);

    // Empty image
    d0 = done_cnt; w0 = we_cnt;
    send_frame(0, 8'd0);
    check("empty_done",     64'(done_cnt - d0), 64'd1);
    check("empty_writes",   64'(we_cnt - w0),   64'd0);
    check("empty_cpu_hold", 64'(cpu_hold),      64'd0);

    // Bad checksum, then recovery with the good image
    d0 = done_cnt; w0 = we_cnt;
    send_frame(2, 8'd1);
    check("badchk_writes",   64'(we_cnt - w0),   64'd2);
    check("badchk_done",     64'(done_cnt - d0), 64'd0);
    check("badchk_error",    64'(error),         64'd1);
    check("badchk_cpu_hold", 64'(cpu_hold),      64'd1);
    check("badchk_busy",     64'(busy),          64'd0);
    d0 = done_cnt;
    send_frame(2, 8'd0);
    check("recover_error",    64'(error),         64'd0);
    check("recover_done",     64'(done_cnt - d0), 64'd1);
    check("recover_cpu_hold", 64'(cpu_hold),      64'd0);

    // Non-header bytes and a short glitch are ignored
    d0 = done_cnt; w0 = we_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("noise_busy",     64'(busy),          64'd0);
    check("noise_writes",   64'(we_cnt - w0),   64'd0);
    check("noise_done",     64'(done_cnt - d0), 64'd0);
    check("noise_error",    64'(error),         64'd0);
    check("noise_cpu_hold", 64'(cpu_hold),      64'd0);

    // Inter-byte timeout in DATA
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check("tmo_mid_busy",     64'(busy),     64'd1);
    check("tmo_mid_cpu_hold", 64'(cpu_hold), 64'd1);
    repeat (TMO + 100) @(negedge clk);
    check("tmo_error",    64'(error),    64'd1);
    check("tmo_busy",     64'(busy),     64'd0);
    check("tmo_cpu_hold", 64'(cpu_hold), 64'd1);

    // Framing error in DATA
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    check("ferr_pre_error", 64'(error), 64'd0);
    send_byte(8'h11, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_error", 64'(error), 64'd1);
    check("ferr_busy",  64'(busy),  64'd0);

    // Length one past the RAM size is rejected
    send_byte(8'hA5);
    check("ovf_pre_error", 64'(error), 64'd0);
    send_byte(8'h09);
    send_byte(8'h00);
    repeat (10) @(negedge clk);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_busy",  64'(busy),  64'd0);

    // Full-RAM image wraps the address back to zero
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back($urandom);
    d0 = done_cnt; w0 = we_cnt;
    send_frame(8, 8'd0);
    check("full_writes",   64'(we_cnt - w0),   64'd8);
    check("full_done",     64'(done_cnt - d0), 64'd1);
    check("full_addr",     64'(mem_addr),      64'd0);
    check("full_error",    64'(error),         64'd0);
    check("full_cpu_hold", 64'(cpu_hold),      64'd0);

    // Asynchronous reset mid-DATA, then a clean load from address 0
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_busy",     64'(busy),     64'd1);
    check("mid_cpu_hold", 64'(cpu_hold), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    img = '{32'hCAFEF00D, 32'h12345678};
    d0 = done_cnt; w0 = we_cnt;
    send_frame(2, 8'd0);
    check("post_rst_writes",   64'(we_cnt - w0),   64'd2);
    check("post_rst_done",     64'(done_cnt - d0), 64'd1);
    check("post_rst_addr",     64'(mem_addr),      64'd2);
    check("post_rst_sb_empty", 64'(exp_q.size()),  64'd0);
    check("post_rst_cpu_hold", 64'(cpu_hold),      64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
